sha256_round_engine: RTL

//  SHA-256 compression engine on the consumer side of the ID/EX pipeline register's SHA controls.
//  - The EX stage loads one 512-bit block as 16 words.
//  - It pulses start_sha_in; the engine runs NUM_ROUNDS rounds and adds the result into the chaining hash H0..H7.
//  - It signals done. The EX result mux reads H words back through rd_sel.

---
 rtl/sha256_round_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: loads a 16-word block, runs NUM_ROUNDS rounds
// and folds the working variables into the chaining hash H0..H7.
module sha256_round_engine #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_sha_in,
  input  logic        init_hash,
  input  logic        msg_we,
  input  logic [3:0]  msg_idx,
  input  logic [31:0] msg_data,
  input  logic [2:0]  rd_sel,
  output logic [31:0] digest_word,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic        init_q, init_d;
  logic        done_q, done_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];

  logic [3:0]  ti;
  logic [31:0] wt, t1, t2;

  // Schedule words live in a 16-entry ring; W[t-16] sits in the slot being overwritten.
  always_comb begin
    ti = t_q[3:0];
    if (t_q[5:4] == 2'b00)
      wt = w_q[ti];
    else
      wt = small_s1(w_q[ti - 4'd2]) + w_q[ti - 4'd7] + small_s0(w_q[ti - 4'd15]) + w_q[ti];
    t1 = v_q[7] + big_s1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K_ROM[t_q] + wt;
    t2 = big_s0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    init_d  = init_q;
    done_d  = 1'b0;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (msg_we) w_d[msg_idx] = msg_data;
        if (start_sha_in) begin
          init_d  = init_hash;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (init_q) begin
          h_d = IV;
          v_d = IV;
        end else begin
          v_d = h_q;
        end
        t_d     = '0;
        state_d = ROUND;
      end
      ROUND: begin
        w_d[ti] = wt;
        for (int i = 7; i > 0; i--) v_d[i] = v_q[i-1];
        v_d[4] = v_q[3] + t1;
        v_d[0] = t1 + t2;
        if (t_q == 6'(NUM_ROUNDS - 1)) state_d = FINAL;
        else t_d = t_q + 6'd1;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      init_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= IV[i];
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      init_q  <= init_d;
      done_q  <= done_d;
      h_q     <= h_d;
      v_q     <= v_d;
      w_q     <= w_d;
    end
  end

  assign digest_word = h_q[rd_sel];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule
